// File: rtl/mem_ctrl.sv
// Memory/device access controller: runs one CS-initiated access through
// IDLE -> ACCESS -> WAIT -> DONE and serves the keyboard/display registers.
module mem_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CS,
  input  logic        WE,
  input  logic [15:0] ADDR,
  input  logic [15:0] WDATA,
  output logic [15:0] RDATA,
  output logic        READY,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        dd_valid,
  output logic [7:0]  dd_data,
  input  logic        dd_ready
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  localparam logic [15:0] DEV_BASE  = 16'hFE00;
  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;
  localparam logic [3:0]  CNT_LOAD  = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        we_q;
  logic [15:0] rdata_q;
  logic        kb_full;
  logic [7:0]  kbd;
  logic        dd_valid_q;
  logic [7:0]  dd_data_q;

  logic        is_dev;
  logic        enter_done;
  logic [15:0] dev_rdata;

  assign is_dev     = (addr_q >= DEV_BASE);
  assign enter_done = (state_q == WAIT) && (cnt_q == 4'd0);

  // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (CS) state_d = ACCESS;
      ACCESS:  state_d = WAIT;
      WAIT:    if (cnt_q == 4'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dev_rdata = 16'h0000;
    case (addr_q)
      KBSR_ADDR: dev_rdata = {kb_full, 15'b0};
      KBDR_ADDR: dev_rdata = {8'h00, kbd};
      DSR_ADDR:  dev_rdata = {~dd_valid_q, 15'b0};
      default:   dev_rdata = 16'h0000;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, regardless of block order.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && CS) begin
        addr_q  <= ADDR;
        wdata_q <= WDATA;
        we_q    <= WE;
      end
      if (state_q == ACCESS)
        cnt_q <= CNT_LOAD;
      else if (state_q == WAIT && cnt_q != 4'd0)
        cnt_q <= cnt_q - 4'd1;
    end
  end

  // Read data lands on the edge entering DONE; writes leave it untouched.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      rdata_q <= 16'h0000;
    else if (enter_done && !we_q)
      rdata_q <= is_dev ? dev_rdata : mem_rdata;
  end

  // A fresh keystroke beats the clear from a simultaneous KBDR read.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      kb_full <= 1'b0;
      kbd     <= 8'h00;
    end else if (kb_valid) begin
      kb_full <= 1'b1;
      kbd     <= kb_data;
    end else if (enter_done && !we_q && addr_q == KBDR_ADDR) begin
      kb_full <= 1'b0;
    end
  end

  // A DDR write is only accepted while no character is pending.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dd_valid_q <= 1'b0;
      dd_data_q  <= 8'h00;
    end else if (enter_done && we_q && addr_q == DDR_ADDR && !dd_valid_q) begin
      dd_valid_q <= 1'b1;
      dd_data_q  <= wdata_q[7:0];
    end else if (dd_valid_q && dd_ready) begin
      dd_valid_q <= 1'b0;
    end
  end

  assign mem_en    = (state_q == ACCESS) && !is_dev;
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign RDATA     = rdata_q;
  assign READY     = (state_q == DONE);
  assign dd_valid  = dd_valid_q;
  assign dd_data   = dd_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: SRAM read/write, keyboard and display
// registers, reset mid-access, and latency at WAIT_CYCLES of 1, 2 and 15.
module tb_mem_ctrl;

  localparam int W = 2;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        CS, WE;
  logic [15:0] ADDR, WDATA;
  logic [15:0] RDATA;
  logic        READY;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        kb_valid;
  logic [7:0]  kb_data;
  logic        dd_valid;
  logic [7:0]  dd_data;
  logic        dd_ready;

  // Latency-sweep instances share address/data, each has its own CS.
  logic        cs1, cs15;
  logic [15:0] addr_s;
  logic [15:0] rdata1, rdata15, maddr1, maddr15, mwd1, mwd15;
  logic        ready1, ready15, en1, en15, mwe1, mwe15, ddv1, ddv15;
  logic [7:0]  ddd1, ddd15;

  logic [15:0] sram [0:65535];

  int errors = 0;
  int checks = 0;
  int r_cyc, r_cnt, en_cyc, en_cnt, we_cnt;

  always #5 CLK = ~CLK;

  mem_ctrl #(.WAIT_CYCLES(W)) dut (
    .CLK(CLK), .RESET(RESET), .CS(CS), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
    .RDATA(RDATA), .READY(READY), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .kb_valid(kb_valid), .kb_data(kb_data), .dd_valid(dd_valid),
    .dd_data(dd_data), .dd_ready(dd_ready)
  );

  mem_ctrl #(.WAIT_CYCLES(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .CS(cs1), .WE(1'b0), .ADDR(addr_s), .WDATA(16'h0000),
    .RDATA(rdata1), .READY(ready1), .mem_en(en1), .mem_we(mwe1),
    .mem_addr(maddr1), .mem_wdata(mwd1), .mem_rdata(16'h0000),
    .kb_valid(1'b0), .kb_data(8'h00), .dd_valid(ddv1),
    .dd_data(ddd1), .dd_ready(1'b0)
  );

  mem_ctrl #(.WAIT_CYCLES(15)) dut15 (
    .CLK(CLK), .RESET(RESET), .CS(cs15), .WE(1'b0), .ADDR(addr_s), .WDATA(16'h0000),
    .RDATA(rdata15), .READY(ready15), .mem_en(en15), .mem_we(mwe15),
    .mem_addr(maddr15), .mem_wdata(mwd15), .mem_rdata(16'h0000),
    .kb_valid(1'b0), .kb_data(8'h00), .dd_valid(ddv15),
    .dd_data(ddd15), .dd_ready(1'b0)
  );

  // NOTE: the SRAM array is not reset; contents are preloaded, as real SRAM holds whatever it powers up with.
  always @(posedge CLK) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= sram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one access on the W=2 instance; cycle 0 is the IDLE cycle with CS=1.
  // kb_at selects a cycle in which kb_valid pulses (0 = none).
  task automatic do_access(input logic we_i, input logic [15:0] addr_i,
                           input logic [15:0] wdata_i, input int kb_at);
    @(negedge CLK);
    CS = 1'b1; WE = we_i; ADDR = addr_i; WDATA = wdata_i;
    r_cyc = -1; r_cnt = 0; en_cyc = -1; en_cnt = 0; we_cnt = 0;
    for (int k = 1; k <= W + 6; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      kb_valid = (k == kb_at);
      if (READY) begin
        r_cnt++;
        if (r_cyc < 0) r_cyc = k;
        CS = 1'b0;
      end
      if (mem_en) begin en_cnt++; en_cyc = k; end
      if (mem_we) we_cnt++;
    end
    CS = 1'b0;
    kb_valid = 1'b0;
  endtask

  task automatic sweep(input int which);
    logic r, e;
    @(negedge CLK);
    if (which == 1) cs1 = 1'b1; else cs15 = 1'b1;
    r_cyc = -1; r_cnt = 0; en_cnt = 0;
    for (int k = 1; k <= 22; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      r = (which == 1) ? ready1 : ready15;
      e = (which == 1) ? en1 : en15;
      if (r) begin
        r_cnt++;
        if (r_cyc < 0) r_cyc = k;
        cs1 = 1'b0; cs15 = 1'b0;
      end
      if (e) en_cnt++;
    end
    cs1 = 1'b0; cs15 = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; CS = 1'b0; WE = 1'b0; ADDR = 16'h0000; WDATA = 16'h0000;
    kb_valid = 1'b0; kb_data = 8'h00; dd_ready = 1'b0;
    cs1 = 1'b0; cs15 = 1'b0; addr_s = 16'hFE04;
    sram[16'h3000] = 16'h1234;
    sram[16'h4000] = 16'h0000;

    repeat (3) @(negedge CLK);
    check("reset_outs", {READY, RDATA, mem_en, mem_we, dd_valid, dd_data}, 32'h0);
    check("reset_bus", {mem_addr, mem_wdata}, 32'h0);
    check("reset_sweep", {ready1, ready15, en1, en15, mwe1, mwe15, ddv1, ddv15,
                          ddd1, ddd15, rdata1 | rdata15 | maddr1 | maddr15 | mwd1 | mwd15}, 32'h0);
    RESET = 1'b0;

    // SRAM read, W=2
    do_access(1'b0, 16'h3000, 16'h0000, 0);
    check("rd_ready_cycle", r_cyc, W + 2);
    check("rd_ready_pulses", r_cnt, 1);
    check("rd_en_cycle", en_cyc, 1);
    check("rd_en_count", en_cnt, 1);
    check("rd_rdata", RDATA, 16'h1234);

    // SRAM write then read back
    do_access(1'b1, 16'h4000, 16'hBEEF, 0);
    check("wr_we_count", we_cnt, 1);
    check("wr_rdata_held", RDATA, 16'h1234);
    check("wr_ready_cycle", r_cyc, W + 2);
    do_access(1'b0, 16'h4000, 16'h0000, 0);
    check("rdback_rdata", RDATA, 16'hBEEF);

    // Keyboard
    @(negedge CLK); kb_valid = 1'b1; kb_data = 8'h41;
    @(negedge CLK); kb_valid = 1'b0;
    do_access(1'b0, 16'hFE00, 16'h0000, 0);
    check("kbsr_full", RDATA, 16'h8000);
    check("kbsr_no_strobe", en_cnt, 0);
    do_access(1'b0, 16'hFE02, 16'h0000, 0);
    check("kbdr_data", RDATA, 16'h0041);
    do_access(1'b0, 16'hFE00, 16'h0000, 0);
    check("kbsr_cleared", RDATA, 16'h0000);
    do_access(1'b1, 16'hFE00, 16'hFFFF, 0);
    check("kbsr_write_ignored_rdata", RDATA, 16'h0000);
    do_access(1'b0, 16'hFE00, 16'h0000, 0);
    check("kbsr_write_ignored", RDATA, 16'h0000);
    // New character arrives on the very edge a KBDR read enters DONE.
    @(negedge CLK); kb_valid = 1'b1; kb_data = 8'h41;
    @(negedge CLK); kb_valid = 1'b0; kb_data = 8'h42;
    do_access(1'b0, 16'hFE02, 16'h0000, W + 1);
    check("kbdr_race_old", RDATA, 16'h0041);
    do_access(1'b0, 16'hFE00, 16'h0000, 0);
    check("kbsr_race_set_wins", RDATA, 16'h8000);
    do_access(1'b0, 16'hFE02, 16'h0000, 0);
    check("kbdr_race_new", RDATA, 16'h0042);

    // Display
    do_access(1'b1, 16'hFE06, 16'h0058, 0);
    check("ddr_valid", dd_valid, 1'b1);
    check("ddr_data", dd_data, 8'h58);
    check("ddr_rdata_held", RDATA, 16'h0042);
    do_access(1'b0, 16'hFE04, 16'h0000, 0);
    check("dsr_busy", RDATA, 16'h0000);
    do_access(1'b1, 16'hFE06, 16'h0059, 0);
    check("ddr_drop_ready", r_cnt, 1);
    check("ddr_drop_data", dd_data, 8'h58);
    @(negedge CLK); dd_ready = 1'b1;
    @(negedge CLK); dd_ready = 1'b0;
    check("dd_accept", dd_valid, 1'b0);
    do_access(1'b0, 16'hFE04, 16'h0000, 0);
    check("dsr_idle", RDATA, 16'h8000);
    do_access(1'b0, 16'hFE10, 16'h0000, 0);
    check("dev_unmapped", RDATA, 16'h0000);

    // Reset in the first WAIT cycle, CS kept high through and after it
    r_cnt = 0; r_cyc = -1;
    @(negedge CLK); CS = 1'b1; WE = 1'b0; ADDR = 16'h3000;
    @(posedge CLK); @(negedge CLK);
    @(posedge CLK); @(negedge CLK);
    RESET = 1'b1;
    #1;
    check("rst_mid_rdata", RDATA, 16'h0000);
    check("rst_mid_ready", READY, 1'b0);
    @(posedge CLK); @(negedge CLK);
    check("rst_mid_ready_held", READY, 1'b0);
    RESET = 1'b0;
    for (int k = 1; k <= W + 5; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (READY) begin
        r_cnt++;
        if (r_cyc < 0) r_cyc = k;
        CS = 1'b0;
      end
    end
    CS = 1'b0;
    check("rst_restart_cycle", r_cyc, W + 2);
    check("rst_restart_pulses", r_cnt, 1);
    check("rst_restart_rdata", RDATA, 16'h1234);

    // Latency sweep in device space
    sweep(1);
    check("w1_ready_cycle", r_cyc, 3);
    check("w1_ready_pulses", r_cnt, 1);
    check("w1_no_strobe", en_cnt, 0);
    check("w1_rdata", rdata1, 16'h8000);
    sweep(15);
    check("w15_ready_cycle", r_cyc, 17);
    check("w15_ready_pulses", r_cnt, 1);
    check("w15_no_strobe", en_cnt, 0);
    check("w15_rdata", rdata15, 16'h8000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, number of wait cycles after the SRAM strobe; the legal range is 1..15.
REQ-002 CLK  in  1  system clock; all state changes on the rising edge.
REQ-003 RESET  in  1  asynchronous, active-high reset.
REQ-004 CS  in  1  access request from the control FSM; held high until READY is seen.
REQ-005 WE  in  1  write enable from the FSM; 1=write, 0=read; sampled with CS.
REQ-006 ADDR  in  16  access address (MAR).
REQ-007 WDATA  in  16  write data (MDR).
REQ-008 RDATA  out  16  read data to the MDR; registered.
REQ-009 READY  out  1  access-complete pulse to the FSM.
REQ-010 mem_en / mem_we  out  1 each  synchronous SRAM strobe and write enable.
REQ-011 mem_addr / mem_wdata  out  16 each  SRAM address and write data.
REQ-012 mem_rdata  in  16  SRAM read data; valid one cycle after mem_en.
REQ-013 kb_valid / kb_data  in  1 / 8  keyboard character pulse and character.
REQ-014 dd_valid / dd_data  out  1 / 8  display character offer.
REQ-015 dd_ready  in  1  display accepts the character when dd_valid=1.

Function
REQ-016 The FSM SHALL have four states: IDLE, ACCESS, WAIT and DONE.
REQ-017 IDLE and CS=1 SHALL latch ADDR, WDATA and WE, then go to ACCESS.
- CS=0 in ACCESS, WAIT or DONE is ignored.
REQ-018 ACCESS SHALL last 1 cycle, then go to WAIT.
- SRAM space (ADDR<0xFE00): mem_en=1; mem_we=latched WE; mem_addr/mem_wdata = latched values.
- Device space (ADDR≥0xFE00): mem_en=0.
REQ-019 WAIT SHALL last exactly WAIT_CYCLES cycles using a 4-bit down-counter, then go to DONE.
REQ-020 DONE SHALL last 1 cycle with READY=1, then return to IDLE.
- If CS is held, the access is not restarted in that DONE cycle.
REQ-021 Latency: if cycle 0 is the IDLE cycle with CS=1, READY SHALL be high in cycle WAIT_CYCLES+2 only.
REQ-022 Read, at the edge entering DONE, RDATA SHALL load:
- SRAM space: mem_rdata.
- Device space: the addressed device register.
REQ-023 Write: RDATA SHALL hold its previous value.
REQ-024 Device map:
- 0xFE00 KBSR = {kb_full,15'b0}.
- 0xFE02 KBDR = {8'h00,kbd}.
- 0xFE04 DSR = {~dd_valid,15'b0}.
- 0xFE06 DDR: write-only.
- Other ≥0xFE00: read 0, writes ignored.
- Writes to KBSR, DSR and KBDR SHALL be ignored.
REQ-025 kb_valid=1 SHALL load kbd←kb_data and set kb_full; a new character overwrites an unread one.
REQ-026 kb_full SHALL clear at the edge entering DONE of a KBDR read.
- If kb_valid occurs on the same edge, set wins and the new character is latched.
REQ-027 DDR write while dd_valid=0 SHALL load dd_data←WDATA[7:0] and set dd_valid at the edge entering DONE.
- DDR write while dd_valid=1 is dropped, but READY still completes.
REQ-028 dd_valid SHALL clear on the edge where dd_valid=1 and dd_ready=1.
- If a new DDR write lands on that same edge, it is dropped (dd_valid=1 at write time).

Reset
REQ-029 RESET SHALL force IDLE and drive outputs to: READY=0, RDATA=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, dd_valid=0, dd_data=0. It SHALL also clear kb_full, kbd and the counter.
REQ-030 RESET during WAIT or DONE SHALL abort the access with no READY.
- An SRAM write already strobed in ACCESS is not undone.
REQ-031 After RESET deasserts, a held CS SHALL start a new access from IDLE.

Verification
REQ-032 SRAM read, W=2: SRAM[0x3000]=0x1234, CS=1 WE=0 ADDR=0x3000 in cycle 0 -> mem_en=1 in cycle 1, READY=1 only in cycle 4, RDATA=0x1234.
REQ-033 SRAM write then read: write 0xBEEF to 0x4000 -> mem_we=1 for one cycle, RDATA unchanged; read 0x4000 -> RDATA=0xBEEF.
REQ-034 Keyboard:
- kb_valid with 0x41 -> read 0xFE00 returns 0x8000, read 0xFE02 returns 0x0041, read 0xFE00 then returns 0x0000.
- kb_valid on the KBDR-read DONE edge -> KBSR remains 0x8000.
REQ-035 Display: write 0x0058 to 0xFE06 with dd_ready=0 -> dd_valid=1, dd_data=0x58, DSR=0x0000; a second DDR write is dropped; dd_ready=1 -> dd_valid=0, DSR=0x8000.
REQ-036 Reset mid-access: RESET asserted in the first WAIT cycle -> state IDLE, READY never pulses, RDATA=0; CS still high after release -> READY WAIT_CYCLES+2 cycles later.
REQ-037 Latency sweep: WAIT_CYCLES=1 and 15 -> READY at cycle 3 and 17; mem_en in device space stays 0 throughout.
